bin_to_bcd_n: RTL
=================

// Module: bin_to_bcd_n
// PURPOSE
//  Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
//  Generalises the fixed 14-bit/4-digit converter used in the display paths.
//  Adds overflow detection, a leading-zero blank mask, and result registers that stay stable during conversion.
//  Sits between counters/timers and sseg display multiplexers.
// PARAMETERS
//  BIN_W   14  binary input width in bits; legal range >= 2
//  DIGITS   4  number of BCD output digits; legal range >= 1
// PORTS
//  i_clk    in   1           clock; all logic on the rising edge
//  i_rst    in   1           reset, synchronous, active-high
//  i_start  in   1           request a conversion; sampled only while o_ready=1
//  i_bin    in   BIN_W       unsigned binary operand; captured with i_start
//  o_ready  out  1           converter idle; will accept i_start
//  o_done   out  1           one-cycle pulse; o_bcd/o_ovf/o_blank updated this cycle
//  o_ovf    out  1           i_bin of last conversion > 10^DIGITS-1
//  o_bcd    out  4*DIGITS    result digits; digit k in bits [4k+3:4k], digit 0 = units
//  o_blank  out  DIGITS      bit k=1: digit k is a leading zero (display blank)
// BEHAVIOUR
//  Reset (sync, i_rst=1 at edge) forces the following state; i_rst overrides every other input:
//   - state READY, working regs 0
//   - o_bcd=0, o_ovf=0, o_done=0, o_ready=1
//   - o_blank = all ones except bit 0
//  Reset mid-conversion aborts it; no o_done is issued; results are cleared.
//  FSM states and transitions:
//   - READY: o_ready=1. If i_start is high, capture i_bin and clear the working digits and sticky ovf.
//     Load idx=BIN_W, then go to OP.
//   - OP: if idx!=0, do one double-dabble step:
//     * each working digit d, if d>4, becomes d+3
//     * shift the chain left one bit, with MSB of bin entering digit 0
//     * bit 3 of adjusted digit DIGITS-1 is shifted out; if it is 1, set sticky ovf
//     * idx <= idx-1
//     If idx==0: copy working digits and sticky ovf to the output registers, then go to DONE.
//   - DONE: o_done=1 for exactly one cycle, then go to READY.
//  Latency: i_start sampled at edge E0 -> o_done high in cycle E0+BIN_W+2. For the defaults this is 16 cycles.
//  Next i_start is accepted one cycle after o_done, giving a throughput of BIN_W+3 cycles per conversion.
//  i_start while o_ready=0 is ignored; it is neither queued nor flagged. i_bin is don't-care outside acceptance.
//  o_bcd, o_ovf and o_blank:
//   - change only in the DONE-entry cycle (with o_done) or on reset
//   - hold the previous result during OP
//  Overflow: the output digits equal i_bin mod 10^DIGITS, and o_ovf=1.
//   - if 10^DIGITS > 2^BIN_W-1, o_ovf is constant 0 after reset
//  o_blank is combinational from o_bcd:
//   - bit k = 1 iff digits k..DIGITS-1 are all zero, for k>=1
//   - bit 0 is always 0, so a single zero is always shown
//  Internal index counter width is $clog2(BIN_W+1). Digit adds are 4-bit with no carry between digits.
// TESTING
//  1. BIN_W=14,DIGITS=4: i_bin=9999 -> o_bcd=16'h9999, o_ovf=0, o_blank=4'b0000, o_done 16 cycles after start.
//  2. i_bin=42 -> o_bcd=16'h0042, o_blank=4'b1100; then i_bin=0 -> o_bcd=16'h0000, o_blank=4'b1110.
//  3. i_bin=16383 -> o_bcd=16'h6383, o_ovf=1; then i_bin=10000 -> 16'h0000, o_ovf=1.
//     Next i_bin=1 -> o_ovf=0.
//  4. Pulse i_start every cycle during a conversion of 1234:
//     - exactly one o_done; o_bcd=16'h1234
//     - o_bcd holds the prior result during OP
//  5. Start 5678, assert i_rst at cycle 7 -> next cycle o_ready=1, o_bcd=0, o_blank=4'b1110; no o_done.
//     Then 0321 converts correctly.
//  6. BIN_W=20,DIGITS=7 and BIN_W=8,DIGITS=2: 2000 random values plus 0 and max, back-to-back.
//     Check digits vs model (v mod 10^DIGITS), o_ovf and o_blank vs the model.

Source files
------------

// File: rtl/bin_to_bcd_n.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// overflow flag, leading-zero blank mask and result registers held during conversion.
module bin_to_bcd_n #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_ovf,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_blank
);

  localparam int IDX_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_READY,
    S_OP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   adj;
  logic               ovf_work_q, ovf_work_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  // Per-digit add-3 correction; no carry crosses digit boundaries.
  always_comb begin
    adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] > 4'd4) adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    work_d     = work_q;
    ovf_work_d = ovf_work_q;
    idx_d      = idx_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_READY: begin
        if (i_start) begin
          bin_d      = i_bin;
          work_d     = '0;
          ovf_work_d = 1'b0;
          idx_d      = IDX_W'(BIN_W);
          state_d    = S_OP;
        end
      end
      S_OP: begin
        if (idx_q != '0) begin
          // Bit 3 of the top adjusted digit leaves the chain: that is a 10^DIGITS carry.
          work_d     = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
          ovf_work_d = ovf_work_q | adj[BCD_W-1];
          bin_d      = bin_q << 1;
          idx_d      = idx_q - IDX_W'(1);
        end else begin
          bcd_d   = work_q;
          ovf_d   = ovf_work_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_READY;
      default: state_d = S_READY;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_READY;
      bin_q      <= '0;
      work_q     <= '0;
      ovf_work_q <= 1'b0;
      idx_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      ovf_work_q <= ovf_work_d;
      idx_q      <= idx_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_ready = (state_q == S_READY);
  assign o_done  = (state_q == S_DONE);
  assign o_bcd   = bcd_q;
  assign o_ovf   = ovf_q;

  // Units digit is never blanked so a zero value still shows one '0'.
  assign o_blank[0] = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : g_blank
    assign o_blank[k] = ~|bcd_q[BCD_W-1:4*k];
  end

endmodule
